irq_controller: RTL and testbench

Parametrised interrupt controller for the fastClk domain. It replaces the hard-wired two-source keyboard/breakpoint interrupt logic at the top level. NUM_SRC asynchronous level sources are synchronised, edge-detected and held as per-source pending bits, and the block arbitrates by fixed priority. It presents one IRQ with latched payload data, vector address and source index to the CPU, and releases it on a synchronised acknowledge.

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_controller_if.sv | 42 ++++
 rtl/irq_sync_edge.sv | 39 +++
 rtl/irq_controller.sv | 145 ++++++++++++++
 tb/tb_irq_controller.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// ============================================================================
// Module  : irq_pkg
// Brief   : Shared types and constants for the fastClk interrupt controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      RELEASE = 2'd2
   } irq_state_t;

   localparam int ACK_SYNC_STAGES = 2;

   // Source index width, never narrower than one bit
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_controller_if.sv
// ============================================================================
// Module  : irq_controller_if
// Brief   : Source/CPU-side signal bundle of the interrupt controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_controller_if #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 32
);
   import irq_pkg::*;

   localparam int IDX_W = idx_w(NUM_SRC);

   logic [NUM_SRC-1:0]        srcLevel;
   logic [NUM_SRC*DATA_W-1:0] srcData;
   logic [NUM_SRC-1:0]        srcEnable;
   logic                      globalEn;
   logic [ADDR_W-1:0]         vecAddr;
   logic                      ack;
   logic                      irq;
   logic [DATA_W-1:0]         irqData;
   logic [ADDR_W-1:0]         irqAddr;
   logic [IDX_W-1:0]          irqSrc;
   logic [NUM_SRC-1:0]        pending;
   logic [NUM_SRC-1:0]        overflow;

   modport master (
      output srcLevel, srcData, srcEnable, globalEn, vecAddr, ack,
      input  irq, irqData, irqAddr, irqSrc, pending, overflow
   );

   modport slave (
      input  srcLevel, srcData, srcEnable, globalEn, vecAddr, ack,
      output irq, irqData, irqAddr, irqSrc, pending, overflow
   );

endinterface

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// ============================================================================
// Module  : irq_sync_edge
// Brief   : Multi-flop synchroniser with a registered rising-edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic fastClk,
   input  logic rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   logic              r_rise;

   always_ff @(posedge fastClk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
         r_prev <= r_sync[STAGES-1];
         r_rise <= r_sync[STAGES-1] & ~r_prev;
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// Module  : irq_controller
// Brief   : Fixed-priority interrupt controller with pending/overflow tracking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_controller
   import irq_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 32,
   parameter int SYNC_STAGES = 3
) (
   input  logic             fastClk,
   input  logic             rst,
   irq_controller_if.slave  bus
);

   localparam int IDX_W = idx_w(NUM_SRC);

   irq_state_t          r_state;
   irq_state_t          w_nextState;
   logic [NUM_SRC-1:0]  w_srcRise;
   logic [NUM_SRC-1:0]  w_srcLevelUnused;
   logic                w_ackLevel;
   logic                w_ackRise;
   logic [NUM_SRC-1:0]  r_pending;
   logic [NUM_SRC-1:0]  r_overflow;
   logic [DATA_W-1:0]   r_data [NUM_SRC];
   logic [IDX_W-1:0]    r_irqSrc;
   logic [DATA_W-1:0]   r_irqData;
   logic [ADDR_W-1:0]   r_irqAddr;
   logic [IDX_W-1:0]    w_sel;
   logic                w_any;
   logic                w_issue;
   logic                w_release;
   logic                w_irq;
   logic [NUM_SRC-1:0]  w_set;
   logic [NUM_SRC-1:0]  w_clr;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
         .fastClk (fastClk),
         .rst     (rst),
         .i_async (bus.srcLevel[g]),
         .o_level (w_srcLevelUnused[g]),
         .o_rise  (w_srcRise[g])
      );
   end

   irq_sync_edge #(.STAGES(ACK_SYNC_STAGES)) u_ackSync (
      .fastClk (fastClk),
      .rst     (rst),
      .i_async (bus.ack),
      .o_level (w_ackLevel),
      .o_rise  (w_ackRise)
   );

   // Descending scan so the lowest pending index is the one left selected
   always_comb begin
      w_sel = '0;
      w_any = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_sel = IDX_W'(i);
            w_any = 1'b1;
         end
      end
   end

   always_ff @(posedge fastClk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (bus.globalEn && w_any) w_nextState = ACTIVE;
         ACTIVE:  if (w_ackRise)             w_nextState = RELEASE;
         RELEASE: if (!w_ackLevel)           w_nextState = IDLE;
         default:                            w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_issue   = (r_state == IDLE) && bus.globalEn && w_any;
      w_release = (r_state == ACTIVE) && w_ackRise;
      w_irq     = (r_state == ACTIVE);
   end

   always_comb begin
      w_set = '0;
      w_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_set[i] = w_srcRise[i] & bus.srcEnable[i];
         w_clr[i] = w_release && (r_irqSrc == IDX_W'(i));
      end
   end

   // A new edge beats a same-cycle acknowledge clear; overflow only survives
   // when the source was already pending and is not being serviced
   always_ff @(posedge fastClk) begin
      if (rst) begin
         r_pending  <= '0;
         r_overflow <= '0;
         for (int i = 0; i < NUM_SRC; i++) r_data[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (w_set[i]) begin
               r_data[i]     <= bus.srcData[i*DATA_W +: DATA_W];
               r_pending[i]  <= 1'b1;
               r_overflow[i] <= ~w_clr[i] & (r_overflow[i] | r_pending[i]);
            end else if (w_clr[i]) begin
               r_pending[i]  <= 1'b0;
               r_overflow[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge fastClk) begin
      if (rst) begin
         r_irqSrc  <= '0;
         r_irqData <= '0;
         r_irqAddr <= '0;
      end else if (w_issue) begin
         r_irqSrc  <= w_sel;
         r_irqData <= r_data[w_sel];
         r_irqAddr <= bus.vecAddr;
      end
   end

   assign bus.irq      = w_irq;
   assign bus.irqData  = r_irqData;
   assign bus.irqAddr  = r_irqAddr;
   assign bus.irqSrc   = r_irqSrc;
   assign bus.pending  = r_pending;
   assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// ============================================================================
// Module  : tb_irq_controller
// Brief   : Directed self-checking bench for irq_controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_controller;

   logic fastClk;
   logic rst;
   int   checks;
   int   errors;

   irq_controller_if #(.NUM_SRC(4), .DATA_W(16), .ADDR_W(32)) bus ();

   irq_controller #(
      .NUM_SRC(4), .DATA_W(16), .ADDR_W(32), .SYNC_STAGES(3)
   ) dut (
      .fastClk (fastClk),
      .rst     (rst),
      .bus     (bus)
   );

   initial fastClk = 1'b0;
   always #5 fastClk = ~fastClk;

   task automatic step(input int n);
      repeat (n) @(negedge fastClk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic setData(input int idx, input logic [15:0] v);
      bus.srcData[idx*16 +: 16] = v;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.srcLevel  = '0;
      bus.srcData   = '0;
      bus.srcEnable = '0;
      bus.globalEn  = 1'b0;
      bus.vecAddr   = '0;
      bus.ack       = 1'b0;
      step(3);
      rst = 1'b0;
      chk("rst_irq",      32'(bus.irq),      32'h0);
      chk("rst_pending",  32'(bus.pending),  32'h0);
      chk("rst_overflow", 32'(bus.overflow), 32'h0);
      chk("rst_irqData",  32'(bus.irqData),  32'h0);
      chk("rst_irqAddr",  bus.irqAddr,       32'h0);
      chk("rst_irqSrc",   32'(bus.irqSrc),   32'h0);

      // Single source 2, latency to pending/irq and ack release
      bus.srcEnable = 4'hF;
      bus.globalEn  = 1'b1;
      bus.vecAddr   = 32'h1000_0100;
      setData(2, 16'h00A5);
      bus.srcLevel[2] = 1'b1;
      step(4);
      chk("t1_pend_early", 32'(bus.pending), 32'h0);
      step(1);
      chk("t1_pend",       32'(bus.pending), 32'h4);
      chk("t1_irq_early",  32'(bus.irq),     32'h0);
      step(1);
      chk("t1_irq",        32'(bus.irq),     32'h1);
      chk("t1_src",        32'(bus.irqSrc),  32'h2);
      chk("t1_data",       32'(bus.irqData), 32'h00A5);
      chk("t1_addr",       bus.irqAddr,      32'h1000_0100);
      bus.ack = 1'b1;
      step(3);
      chk("t1_irq_hold",   32'(bus.irq),     32'h1);
      step(1);
      chk("t1_irq_off",    32'(bus.irq),     32'h0);
      chk("t1_pend_clr",   32'(bus.pending), 32'h0);
      bus.ack = 1'b0;
      bus.srcLevel = '0;
      step(4);

      // Sources 3 and 1 together: priority then back-to-back timing
      setData(1, 16'h0111);
      setData(3, 16'h0333);
      bus.srcLevel = 4'b1010;
      step(6);
      chk("t2_irq",     32'(bus.irq),     32'h1);
      chk("t2_src",     32'(bus.irqSrc),  32'h1);
      chk("t2_data",    32'(bus.irqData), 32'h0111);
      chk("t2_pend",    32'(bus.pending), 32'hA);
      bus.ack = 1'b1;
      step(4);
      chk("t2_irq_off", 32'(bus.irq),     32'h0);
      chk("t2_pend2",   32'(bus.pending), 32'h8);
      step(2);
      chk("t2_held",    32'(bus.irq),     32'h0);
      bus.ack = 1'b0;
      step(3);
      chk("t2_b2b_early", 32'(bus.irq),   32'h0);
      step(1);
      chk("t2_irq3",    32'(bus.irq),     32'h1);
      chk("t2_src3",    32'(bus.irqSrc),  32'h3);
      chk("t2_data3",   32'(bus.irqData), 32'h0333);
      bus.ack = 1'b1;
      step(4);
      chk("t2_pend_clr", 32'(bus.pending), 32'h0);
      bus.ack = 1'b0;
      bus.srcLevel = '0;
      step(4);

      // Two events on source 0 before service: overflow, newest payload
      bus.globalEn = 1'b0;
      setData(0, 16'h0011);
      bus.srcLevel[0] = 1'b1;
      step(5);
      chk("t3_pend",   32'(bus.pending),  32'h1);
      chk("t3_ovf0",   32'(bus.overflow), 32'h0);
      bus.srcLevel[0] = 1'b0;
      step(3);
      setData(0, 16'h0022);
      bus.srcLevel[0] = 1'b1;
      step(5);
      chk("t3_ovf1",   32'(bus.overflow), 32'h1);
      chk("t3_pend2",  32'(bus.pending),  32'h1);
      chk("t3_gated",  32'(bus.irq),      32'h0);
      bus.globalEn = 1'b1;
      step(1);
      chk("t3_irq",    32'(bus.irq),      32'h1);
      chk("t3_data",   32'(bus.irqData),  32'h0022);
      bus.ack = 1'b1;
      step(4);
      chk("t3_ovf_clr",  32'(bus.overflow), 32'h0);
      chk("t3_pend_clr", 32'(bus.pending),  32'h0);
      bus.ack = 1'b0;
      bus.srcLevel = '0;
      step(4);

      // Masked edge ignored; masking after pending keeps the bit
      bus.srcEnable = 4'b1101;
      bus.srcLevel[1] = 1'b1;
      step(7);
      chk("t4_mask_pend", 32'(bus.pending), 32'h0);
      chk("t4_mask_irq",  32'(bus.irq),     32'h0);
      bus.srcLevel[1] = 1'b0;
      bus.srcEnable = 4'hF;
      bus.globalEn = 1'b0;
      step(4);
      bus.srcLevel[1] = 1'b1;
      step(5);
      chk("t4_pend",      32'(bus.pending), 32'h2);
      bus.srcEnable = 4'b1101;
      step(2);
      chk("t4_pend_kept", 32'(bus.pending), 32'h2);
      chk("t4_noissue",   32'(bus.irq),     32'h0);
      bus.globalEn = 1'b1;
      step(1);
      chk("t4_irq",       32'(bus.irq),     32'h1);
      chk("t4_src",       32'(bus.irqSrc),  32'h1);
      bus.ack = 1'b1;
      step(4);
      bus.ack = 1'b0;
      bus.srcLevel = '0;
      bus.srcEnable = 4'hF;
      step(4);

      // Held ack services only one of two pending sources
      bus.globalEn = 1'b0;
      setData(0, 16'h00C0);
      setData(2, 16'h00C2);
      bus.srcLevel = 4'b0101;
      step(5);
      chk("t5_pend",     32'(bus.pending), 32'h5);
      bus.globalEn = 1'b1;
      step(1);
      chk("t5_src0",     32'(bus.irqSrc),  32'h0);
      chk("t5_data0",    32'(bus.irqData), 32'h00C0);
      bus.ack = 1'b1;
      step(4);
      chk("t5_pend2",    32'(bus.pending), 32'h4);
      step(6);
      chk("t5_held",     32'(bus.irq),     32'h0);
      bus.ack = 1'b0;
      step(3);
      chk("t5_early",    32'(bus.irq),     32'h0);
      step(1);
      chk("t5_irq2",     32'(bus.irq),     32'h1);
      chk("t5_src2",     32'(bus.irqSrc),  32'h2);
      chk("t5_data2",    32'(bus.irqData), 32'h00C2);
      bus.ack = 1'b1;
      step(4);
      bus.ack = 1'b0;
      bus.srcLevel = '0;
      step(4);

      // New edge on the serviced source in the same cycle as its clear
      bus.globalEn = 1'b0;
      setData(0, 16'h0011);
      bus.srcLevel[0] = 1'b1;
      step(5);
      bus.srcLevel[0] = 1'b0;
      bus.globalEn = 1'b1;
      step(1);
      chk("t6_irq",      32'(bus.irq),      32'h1);
      step(3);
      setData(0, 16'h0044);
      bus.srcLevel[0] = 1'b1;
      step(1);
      bus.ack = 1'b1;
      step(4);
      chk("t6_irq_off",  32'(bus.irq),      32'h0);
      chk("t6_pend",     32'(bus.pending),  32'h1);
      chk("t6_ovf",      32'(bus.overflow), 32'h0);
      bus.ack = 1'b0;
      step(4);
      chk("t6_reissue",  32'(bus.irq),      32'h1);
      chk("t6_data",     32'(bus.irqData),  32'h0044);
      bus.ack = 1'b1;
      step(4);
      bus.ack = 1'b0;
      bus.srcLevel = '0;
      step(4);

      // Reset while ACTIVE drops the interrupt
      setData(3, 16'h0333);
      bus.srcLevel[3] = 1'b1;
      step(6);
      chk("t7_irq",      32'(bus.irq),     32'h1);
      rst = 1'b1;
      bus.srcLevel = '0;
      step(1);
      chk("t7_rst_irq",  32'(bus.irq),     32'h0);
      chk("t7_rst_pend", 32'(bus.pending), 32'h0);
      chk("t7_rst_src",  32'(bus.irqSrc),  32'h0);
      chk("t7_rst_data", 32'(bus.irqData), 32'h0);
      rst = 1'b0;
      step(8);
      chk("t7_idle_irq", 32'(bus.irq),     32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
